id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath. It sits between decode and execute.
- Captures decoded operands, register specifiers and the control bundle. Its registered Rs/Rt, Rd and RegWrite feed the EX-stage forwarding unit and the EX/MEM register.
- Contains the load-use hazard detector. The detector stalls PC and IF/ID and inserts a bubble into EX.
- Honours the debug-unit step enable.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/load_use_detector.sv | 24 ++
 rtl/id_ex_stage_reg.sv | 119 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline registers: control bundle width,
// control bit positions and the bubble control word.
package pipeline_pkg;

    localparam int NB_CTRL = 10;

    localparam int REGWRITE  = 0;
    localparam int MEMREAD   = 1;
    localparam int MEMWRITE  = 2;
    localparam int MEMTOREG  = 3;
    localparam int ALUSRC    = 4;
    localparam int REGDST    = 5;
    localparam int ALUOP_LSB = 6;
    localparam int ALUOP_MSB = 9;

    localparam logic [NB_CTRL-1:0] BUBBLE_CTRL = {NB_CTRL{1'b0}};

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detector: flags an IF/ID instruction that needs the result
// of a load currently sitting in EX.
module load_use_detector #(
    parameter int NB_REG = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_memread,
    input  logic [NB_REG-1:0] i_ex_rt,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    output logic              o_stall
);

    logic w_ex_is_load;
    logic w_src_match;

    // $0 is hard-wired, so a load targeting it can never create a dependency.
    // Rt is compared unconditionally, even when the consumer does not read it.
    assign w_ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rt != {NB_REG{1'b0}});
    assign w_src_match  = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
    assign o_stall      = w_ex_is_load & i_id_valid & w_src_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// debug step enable.
module id_ex_stage_reg #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = pipeline_pkg::NB_CTRL
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_pc_plus4,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_CTRL-1:0] i_ctrl,
    output logic [NB_DATA-1:0] o_pc_plus4,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic               o_valid,
    output logic               o_stall
);

    import pipeline_pkg::MEMREAD;
    import pipeline_pkg::BUBBLE_CTRL;

    logic [NB_DATA-1:0] r_pc_plus4;
    logic [NB_DATA-1:0] r_rs_data;
    logic [NB_DATA-1:0] r_rt_data;
    logic [NB_DATA-1:0] r_imm;
    logic [NB_REG-1:0]  r_rs;
    logic [NB_REG-1:0]  r_rt;
    logic [NB_REG-1:0]  r_rd;
    logic [NB_CTRL-1:0] r_ctrl;
    logic               r_valid;

    logic w_stall;
    logic w_bubble;

    load_use_detector #(
        .NB_REG (NB_REG)
    ) u_load_use_detector (
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_ctrl[MEMREAD]),
        .i_ex_rt      (r_rt),
        .i_id_valid   (i_valid),
        .i_id_rs      (i_rs),
        .i_id_rt      (i_rt),
        .o_stall      (w_stall)
    );

    // Flush and stall both load the same bubble, so flush-over-stall needs no extra logic.
    always_comb begin
        w_bubble = 1'b0;
        if (i_flush || w_stall) begin
            w_bubble = 1'b1;
        end else begin
            w_bubble = 1'b0;
        end
    end

    // Pipeline register body: reset clears, disable holds, bubble zeroes, else capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc_plus4 <= {NB_DATA{1'b0}};
            r_rs_data  <= {NB_DATA{1'b0}};
            r_rt_data  <= {NB_DATA{1'b0}};
            r_imm      <= {NB_DATA{1'b0}};
            r_rs       <= {NB_REG{1'b0}};
            r_rt       <= {NB_REG{1'b0}};
            r_rd       <= {NB_REG{1'b0}};
            r_ctrl     <= BUBBLE_CTRL;
            r_valid    <= 1'b0;
        end else if (i_enable) begin
            if (w_bubble) begin
                r_pc_plus4 <= {NB_DATA{1'b0}};
                r_rs_data  <= {NB_DATA{1'b0}};
                r_rt_data  <= {NB_DATA{1'b0}};
                r_imm      <= {NB_DATA{1'b0}};
                r_rs       <= {NB_REG{1'b0}};
                r_rt       <= {NB_REG{1'b0}};
                r_rd       <= {NB_REG{1'b0}};
                r_ctrl     <= BUBBLE_CTRL;
                r_valid    <= 1'b0;
            end else begin
                r_pc_plus4 <= i_pc_plus4;
                r_rs_data  <= i_rs_data;
                r_rt_data  <= i_rt_data;
                r_imm      <= i_imm;
                r_rs       <= i_rs;
                r_rt       <= i_rt;
                r_rd       <= i_rd;
                r_ctrl     <= i_ctrl;
                r_valid    <= i_valid;
            end
        end
    end

    assign o_pc_plus4 = r_pc_plus4;
    assign o_rs_data  = r_rs_data;
    assign o_rt_data  = r_rt_data;
    assign o_imm      = r_imm;
    assign o_rs       = r_rs;
    assign o_rt       = r_rt;
    assign o_rd       = r_rd;
    assign o_ctrl     = r_ctrl;
    assign o_valid    = r_valid;
    assign o_stall    = w_stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard testbench for id_ex_stage_reg: expected EX contents are queued
// when each instruction is driven and compared one edge later.
module tb_id_ex_stage_reg;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_CTRL = 10;

    typedef struct packed {
        logic [NB_DATA-1:0] pc;
        logic [NB_DATA-1:0] rs_data;
        logic [NB_DATA-1:0] rt_data;
        logic [NB_DATA-1:0] imm;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [NB_REG-1:0]  rd;
        logic [NB_CTRL-1:0] ctrl;
        logic               valid;
    } ex_t;

    localparam logic [NB_CTRL-1:0] C_LW  = 10'h00B;
    localparam logic [NB_CTRL-1:0] C_ADD = 10'h0A1;
    localparam logic [NB_CTRL-1:0] C_RW  = 10'h001;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_enable;
    logic               i_flush;
    logic               i_valid;
    logic [NB_DATA-1:0] i_pc_plus4;
    logic [NB_DATA-1:0] i_rs_data;
    logic [NB_DATA-1:0] i_rt_data;
    logic [NB_DATA-1:0] i_imm;
    logic [NB_REG-1:0]  i_rs;
    logic [NB_REG-1:0]  i_rt;
    logic [NB_REG-1:0]  i_rd;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_DATA-1:0] o_pc_plus4;
    logic [NB_DATA-1:0] o_rs_data;
    logic [NB_DATA-1:0] o_rt_data;
    logic [NB_DATA-1:0] o_imm;
    logic [NB_REG-1:0]  o_rs;
    logic [NB_REG-1:0]  o_rt;
    logic [NB_REG-1:0]  o_rd;
    logic [NB_CTRL-1:0] o_ctrl;
    logic               o_valid;
    logic               o_stall;

    int  n_vec = 0;
    int  n_err = 0;
    ex_t model;
    ex_t sb_q[$];

    id_ex_stage_reg #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .NB_CTRL (NB_CTRL)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .i_pc_plus4 (i_pc_plus4),
        .i_rs_data  (i_rs_data),
        .i_rt_data  (i_rt_data),
        .i_imm      (i_imm),
        .i_rs       (i_rs),
        .i_rt       (i_rt),
        .i_rd       (i_rd),
        .i_ctrl     (i_ctrl),
        .o_pc_plus4 (o_pc_plus4),
        .o_rs_data  (o_rs_data),
        .o_rt_data  (o_rt_data),
        .o_imm      (o_imm),
        .o_rs       (o_rs),
        .o_rt       (o_rt),
        .o_rd       (o_rd),
        .o_ctrl     (o_ctrl),
        .o_valid    (o_valid),
        .o_stall    (o_stall)
    );

    // 100 MHz clock.
    always #5 i_clk = ~i_clk;

    // Watchdog so a broken run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_vec(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ex_t observed();
        return '{o_pc_plus4, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd, o_ctrl, o_valid};
    endfunction

    function automatic logic model_stall();
        return model.valid && model.ctrl[1] && (model.rt != 5'd0) && i_valid &&
               ((model.rt == i_rs) || (model.rt == i_rt));
    endfunction

    task automatic set_instr(input logic [NB_REG-1:0] rs, input logic [NB_REG-1:0] rt,
                             input logic [NB_REG-1:0] rd, input logic [NB_CTRL-1:0] ctrl,
                             input logic valid);
        i_pc_plus4 = $urandom;
        i_rs_data  = $urandom;
        i_rt_data  = $urandom;
        i_imm      = $urandom;
        i_rs       = rs;
        i_rt       = rt;
        i_rd       = rd;
        i_ctrl     = ctrl;
        i_valid    = valid;
    endtask

    // One clock: check stall against the model, queue the expected EX contents, compare after the edge.
    task automatic step(input string tag);
        ex_t nxt;
        ex_t got;
        logic st;
        #1;
        st = model_stall();
        check_vec({tag, ".stall"}, 160'(o_stall), 160'(st));
        nxt = model;
        if (i_enable) begin
            if (i_flush || st) begin
                nxt = '0;
            end else begin
                nxt = '{i_pc_plus4, i_rs_data, i_rt_data, i_imm, i_rs, i_rt, i_rd, i_ctrl, i_valid};
            end
        end
        model = nxt;
        sb_q.push_back(nxt);
        @(posedge i_clk);
        #1;
        got = observed();
        check_vec({tag, ".ex"}, 160'(got), 160'(sb_q.pop_front()));
    endtask

    initial begin
        // Reset with every input driven high.
        i_rst_n    = 1'b0;
        i_enable   = 1'b1;
        i_flush    = 1'b1;
        i_valid    = 1'b1;
        i_pc_plus4 = 32'hFFFF_FFFF;
        i_rs_data  = 32'hFFFF_FFFF;
        i_rt_data  = 32'hFFFF_FFFF;
        i_imm      = 32'hFFFF_FFFF;
        i_rs       = 5'h1F;
        i_rt       = 5'h1F;
        i_rd       = 5'h1F;
        i_ctrl     = 10'h3FF;
        repeat (2) @(posedge i_clk);
        #1;
        check_vec("reset.ex", 160'(observed()), 160'(0));
        check_vec("reset.stall", 160'(o_stall), 160'(0));
        model   = '0;
        i_rst_n = 1'b1;
        i_flush = 1'b0;

        // 1: first capture after reset.
        set_instr(5'd3, 5'd4, 5'd9, C_RW, 1'b1);
        i_rs_data = 32'h1234_5678;
        step("t1");
        check_vec("t1.rs_data", 160'(o_rs_data), 160'(32'h1234_5678));
        check_vec("t1.rs", 160'(o_rs), 160'(5'd3));
        check_vec("t1.valid", 160'(o_valid), 160'(1'b1));

        // 2: load-use produces exactly one bubble.
        set_instr(5'd2, 5'd5, 5'd0, C_LW, 1'b1);
        step("t2.lw");
        set_instr(5'd5, 5'd6, 5'd7, C_ADD, 1'b1);
        #1;
        check_vec("t2.stall_now", 160'(o_stall), 160'(1'b1));
        step("t2.stall");
        check_vec("t2.bubble_ctrl", 160'(o_ctrl), 160'(0));
        check_vec("t2.bubble_valid", 160'(o_valid), 160'(1'b0));
        step("t2.replay");
        check_vec("t2.add_rd", 160'(o_rd), 160'(5'd7));

        // 3: load into $0 never stalls.
        set_instr(5'd1, 5'd0, 5'd0, C_LW, 1'b1);
        step("t3.lw0");
        set_instr(5'd0, 5'd2, 5'd3, C_ADD, 1'b1);
        step("t3.use0");
        check_vec("t3.valid", 160'(o_valid), 160'(1'b1));

        // 4: flush coincident with a pending stall.
        set_instr(5'd2, 5'd5, 5'd0, C_LW, 1'b1);
        step("t4.lw");
        set_instr(5'd5, 5'd6, 5'd7, C_ADD, 1'b1);
        i_flush = 1'b1;
        step("t4.flush");
        i_flush = 1'b0;
        check_vec("t4.bubble_valid", 160'(o_valid), 160'(1'b0));
        step("t4.after");

        // 5: enable low freezes state while stall is still reported.
        set_instr(5'd1, 5'd8, 5'd0, C_LW, 1'b1);
        step("t5.lw");
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_instr((k == 1) ? 5'd4 : 5'd8, (k == 1) ? 5'd8 : 5'd2, 5'd10, C_ADD, 1'b1);
            step("t5.hold");
            check_vec("t5.held_rt", 160'(o_rt), 160'(5'd8));
        end
        i_enable = 1'b1;
        step("t5.stall");
        step("t5.replay");

        // 6: asynchronous reset in the middle of a cycle.
        set_instr(5'd11, 5'd12, 5'd13, 10'h3FF, 1'b1);
        step("t6.load");
        #2;
        i_rst_n = 1'b0;
        #1;
        check_vec("t6.async_ex", 160'(observed()), 160'(0));
        check_vec("t6.async_stall", 160'(o_stall), 160'(0));
        @(negedge i_clk);
        model   = '0;
        i_rst_n = 1'b1;
        set_instr(5'd1, 5'd2, 5'd3, C_ADD, 1'b1);
        step("t6.resume");

        // Random mix of loads, flushes, enables and small register numbers.
        for (int k = 0; k < 60; k++) begin
            set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 31)), 10'($urandom), 1'($urandom));
            i_flush  = ($urandom_range(0, 7) == 0);
            i_enable = ($urandom_range(0, 5) != 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
